// File: rtl/clock_seq_pkg.sv
// Shared definitions for the clock sequencer: sequencing states and a width helper.
package clock_seq_pkg;

  typedef enum logic [1:0] {
    ST_WAIT_LOCK = 2'd0,
    ST_SETTLE    = 2'd1,
    ST_RUN       = 2'd2
  } seq_state_t;

  // Bits needed to count 0..value-1, never less than one so a SETTLE of 1 still synthesises.
  function automatic int clog2_min1(input int value);
    int w;
    w = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << w) < 64'(value)) w = w + 1;
    end
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/clock_sequencer_channel.sv
// One sample clock-enable channel: down-counter with terminal-count strobe, plus an
// active/pending divisor pair so rate changes only ever land on a strobe boundary.
module clock_div_channel
  import clock_seq_pkg::*;
#(
  parameter int DIV_W       = 24,
  parameter int DEFAULT_DIV = 0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_run,
  input  logic             i_load,
  input  logic             i_wr,
  input  logic [DIV_W-1:0] i_wr_value,
  output logic             o_ce,
  output logic             o_apply
);

  logic [DIV_W-1:0] r_cnt;
  logic [DIV_W-1:0] r_active;
  logic [DIV_W-1:0] r_pending;
  logic             r_pend;
  logic [DIV_W-1:0] w_active_nxt;
  logic             w_tc;
  logic             w_apply;

  // The first RUN cycle only loads the counter, which delays the first strobe to D+1 cycles.
  assign w_tc         = i_run && !i_load && (r_cnt == '0);
  // Pending divisors land at the terminal count while running, immediately otherwise.
  assign w_apply      = r_pend && (w_tc || !i_run);
  assign w_active_nxt = w_apply ? r_pending : r_active;
  assign o_ce         = w_tc;
  assign o_apply      = w_apply;

  // Counter, divisor registers and pending flag.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_cnt     <= DIV_W'(DEFAULT_DIV);
      r_active  <= DIV_W'(DEFAULT_DIV);
      r_pending <= DIV_W'(DEFAULT_DIV);
      r_pend    <= 1'b0;
    end else begin
      r_active <= w_active_nxt;
      if (i_load || w_tc) begin
        r_cnt <= w_active_nxt;
      end else if (i_run) begin
        r_cnt <= r_cnt - DIV_W'(1);
      end
      // A write in the same cycle as an apply is kept for the next opportunity.
      if (i_wr) begin
        r_pending <= i_wr_value;
        r_pend    <= 1'b1;
      end else if (w_apply) begin
        r_pend <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/clock_sequencer.sv
// Core-clock companion to the PLL: synchronises lock, holds core reset until lock has
// been stable for SETTLE cycles, then runs NCH programmable clock-enable channels.
//
//   state        | meaning
//   -------------+-----------------------------------------------------------
//   ST_WAIT_LOCK | core held in reset, waiting for synchronised lock
//   ST_SETTLE    | lock seen, counting SETTLE stable cycles; any drop restarts
//   ST_RUN       | core released, channel strobes active
module clock_sequencer
  import clock_seq_pkg::*;
#(
  parameter int NCH         = 2,
  parameter int DIV_W       = 24,
  parameter int SETTLE      = 1024,
  parameter int SYNC_STAGES = 2,
  parameter int DEFAULT_DIV = 0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             pll_locked,
  output logic             core_reset,
  output logic             ready,
  input  logic             div_wr,
  input  logic [2:0]       div_ch,
  input  logic [DIV_W-1:0] div_value,
  output logic             div_ack,
  output logic [NCH-1:0]   ce
);

  localparam int                  SETTLE_W    = clog2_min1(SETTLE);
  localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE - 1);

  seq_state_t             r_state;
  seq_state_t             w_state_nxt;
  logic [SYNC_STAGES-1:0] r_sync;
  logic [SETTLE_W-1:0]    r_settle_cnt;
  logic                   r_was_run;
  logic                   r_ready;
  logic                   r_core_reset;
  logic                   w_lock_s;
  logic                   w_run;
  logic                   w_load;
  logic [NCH-1:0]         w_wr;
  logic [NCH-1:0]         w_ce;
  logic [NCH-1:0]         w_apply;

  assign w_lock_s = r_sync[SYNC_STAGES-1];
  // Masking with lock kills strobes in the very cycle the FSM decides to leave RUN.
  assign w_run    = (r_state == ST_RUN) && w_lock_s;
  assign w_load   = (r_state == ST_RUN) && !r_was_run;

  // Lock synchroniser chain.
  always_ff @(posedge clock) begin
    if (reset) r_sync <= '0;
    else       r_sync <= {r_sync[SYNC_STAGES-2:0], pll_locked};
  end

  // Next-state decode.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_WAIT_LOCK: if (w_lock_s) w_state_nxt = ST_SETTLE;
      ST_SETTLE: begin
        if (!w_lock_s)                         w_state_nxt = ST_WAIT_LOCK;
        else if (r_settle_cnt == SETTLE_LAST)  w_state_nxt = ST_RUN;
      end
      ST_RUN:       if (!w_lock_s) w_state_nxt = ST_WAIT_LOCK;
      default:      w_state_nxt = ST_WAIT_LOCK;
    endcase
  end

  // State register plus outputs registered from the next state so they flip on RUN entry/exit.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= ST_WAIT_LOCK;
      r_was_run    <= 1'b0;
      r_ready      <= 1'b0;
      r_core_reset <= 1'b1;
    end else begin
      r_state      <= w_state_nxt;
      r_was_run    <= (r_state == ST_RUN);
      r_ready      <= (w_state_nxt == ST_RUN);
      r_core_reset <= (w_state_nxt != ST_RUN);
    end
  end

  // Settle interval counter; cleared whenever the FSM is not staying in SETTLE.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_settle_cnt <= '0;
    end else if ((r_state == ST_SETTLE) && (w_state_nxt == ST_SETTLE)) begin
      r_settle_cnt <= r_settle_cnt + SETTLE_W'(1);
    end else begin
      r_settle_cnt <= '0;
    end
  end

  // Write decode; out-of-range channel indices match nothing.
  always_comb begin
    w_wr = '0;
    for (int i = 0; i < NCH; i++) begin
      w_wr[i] = div_wr && (int'(div_ch) == i);
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    clock_div_channel #(
      .DIV_W      (DIV_W),
      .DEFAULT_DIV(DEFAULT_DIV)
    ) u_ch (
      .clock      (clock),
      .reset      (reset),
      .i_run      (w_run),
      .i_load     (w_load),
      .i_wr       (w_wr[g]),
      .i_wr_value (div_value),
      .o_ce       (w_ce[g]),
      .o_apply    (w_apply[g])
    );
  end

  assign ce         = w_ce;
  assign div_ack    = |w_apply;
  assign ready      = r_ready;
  assign core_reset = r_core_reset;

endmodule
